// File: rtl/vpu_src_port_rd_pkg.sv
// Shared constants and types for the VPU operand source port reader.
package vpu_src_port_rd_pkg;

    localparam int OPERAND_WIDTH   = 32;
    localparam int SRAM_R_PORT_CNT = 3;
    localparam int SRC_ADDR_WIDTH  = 10;
    localparam int SRC_LEN_WIDTH   = 8;
    localparam int SRAM_RD_LAT     = 2;
    localparam int SRC_FIFO_DEPTH  = 4;

    typedef logic [1:0] src_state_t;
    localparam src_state_t ST_IDLE  = 2'd0;
    localparam src_state_t ST_ISSUE = 2'd1;
    localparam src_state_t ST_DRAIN = 2'd2;
    localparam src_state_t ST_DONE  = 2'd3;

    typedef logic [OPERAND_WIDTH-1:0] operand_t;

    typedef struct packed {
        operand_t [SRAM_R_PORT_CNT-1:0] op;
        logic                           last;
    } src_entry_t;

endpackage

// File: rtl/vpu_src_port_rd_if.sv
// Command, SRAM read and operand-out bundle; master is the source engine side.
interface vpu_src_port_rd_if
    import vpu_src_port_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = SRC_ADDR_WIDTH,
    parameter int LEN_WIDTH  = SRC_LEN_WIDTH
);
    logic                                      cmd_valid;
    logic                                      cmd_ready;
    logic [SRAM_R_PORT_CNT*ADDR_WIDTH-1:0]     cmd_addr;
    logic [SRAM_R_PORT_CNT-1:0]                cmd_op_mask;
    logic [LEN_WIDTH-1:0]                      cmd_len;
    logic [SRAM_R_PORT_CNT-1:0]                sram_rd_en;
    logic [SRAM_R_PORT_CNT*ADDR_WIDTH-1:0]     sram_rd_addr;
    logic [SRAM_R_PORT_CNT*OPERAND_WIDTH-1:0]  sram_rd_data;
    logic [OPERAND_WIDTH-1:0]                  op_0;
    logic [OPERAND_WIDTH-1:0]                  op_1;
    logic [OPERAND_WIDTH-1:0]                  op_2;
    logic [SRAM_R_PORT_CNT-1:0]                op_valid;
    logic                                      out_valid;
    logic                                      out_ready;
    logic                                      out_last;
    logic                                      done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_op_mask, cmd_len, sram_rd_data, out_ready,
        output cmd_ready, sram_rd_en, sram_rd_addr, op_0, op_1, op_2, op_valid,
               out_valid, out_last, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_op_mask, cmd_len, sram_rd_data, out_ready,
        input  cmd_ready, sram_rd_en, sram_rd_addr, op_0, op_1, op_2, op_valid,
               out_valid, out_last, done
    );

endinterface

// File: rtl/vpu_src_fifo.sv
// Small synchronous FIFO of operand entries; pointers and count cleared on reset.
module vpu_src_fifo
    import vpu_src_port_rd_pkg::*;
#(
    parameter int DEPTH = SRC_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  src_entry_t                 i_din,
    input  logic                       i_pop,
    output src_entry_t                 o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    src_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = w_empty;

endmodule

// File: rtl/vpu_src_port_rd.sv
// Operand source engine: issues per-element SRAM reads and re-aligns the
// returning data into op_0/op_1/op_2 beats under a valid/ready handshake.
module vpu_src_port_rd
    import vpu_src_port_rd_pkg::*;
#(
    parameter int ADDR_WIDTH  = SRC_ADDR_WIDTH,
    parameter int LEN_WIDTH   = SRC_LEN_WIDTH,
    parameter int SRAM_RD_LAT = vpu_src_port_rd_pkg::SRAM_RD_LAT,
    parameter int FIFO_DEPTH  = SRC_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    vpu_src_port_rd_if.master bus
);
    localparam int P   = SRAM_R_PORT_CNT;
    localparam int OW  = OPERAND_WIDTH;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + SRAM_RD_LAT + 1);

    logic [1:0]                   r_state;
    logic [P-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [P-1:0]                 r_mask;
    logic [LEN_WIDTH-1:0]         r_remaining;
    logic [SRAM_RD_LAT-1:0]       r_pipe_vld;
    logic [SRAM_RD_LAT-1:0]       r_pipe_last;

    logic [FCW-1:0]               w_fifo_count;
    logic                         w_fifo_empty;
    logic [SW-1:0]                w_inflight;
    logic [P-1:0][OW-1:0]         w_push_ops;
    src_entry_t                   w_push_entry;
    src_entry_t                   w_head;
    logic                         w_issue;
    logic                         w_arrive;
    logic                         w_out_valid;
    logic                         w_pop;
    logic                         w_last_xfer;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < SRAM_RD_LAT; k++) begin
            w_inflight = w_inflight + SW'(r_pipe_vld[k]);
        end
    end

    // Credit check: every read in flight already owns a FIFO slot, so SRAM
    // returns can always be absorbed even while the ALU stalls.
    assign w_issue     = (r_state == ST_ISSUE) &&
                         ((SW'(w_fifo_count) + w_inflight) < SW'(FIFO_DEPTH));
    assign w_arrive    = r_pipe_vld[SRAM_RD_LAT-1];
    assign w_out_valid = !w_fifo_empty;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_last_xfer = w_pop && w_head.last;

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_port
            assign bus.sram_rd_en[gi] = w_issue && r_mask[gi];
            assign bus.sram_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
                (w_issue && r_mask[gi]) ? r_addr[gi] : '0;
            assign w_push_ops[gi] = r_mask[gi] ? bus.sram_rd_data[gi*OW +: OW] : '0;
        end
    endgenerate

    assign w_push_entry = '{op: w_push_ops, last: r_pipe_last[SRAM_RD_LAT-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else begin
            for (int k = SRAM_RD_LAT - 1; k > 0; k--) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_last[k] <= r_pipe_last[k-1];
            end
            r_pipe_vld[0]  <= w_issue;
            r_pipe_last[0] <= w_issue && (r_remaining == LEN_WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_mask      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_mask      <= bus.cmd_op_mask;
                        r_remaining <= bus.cmd_len;
                        for (int k = 0; k < P; k++) begin
                            r_addr[k] <= bus.cmd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                        r_state <= (bus.cmd_len != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        for (int k = 0; k < P; k++) begin
                            r_addr[k] <= r_addr[k] + ADDR_WIDTH'(1);
                        end
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_xfer) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    vpu_src_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_arrive),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_valid && w_head.last;
    assign bus.op_valid  = w_out_valid ? r_mask : '0;
    assign bus.op_0      = w_out_valid ? w_head.op[0] : '0;
    assign bus.op_1      = w_out_valid ? w_head.op[1] : '0;
    assign bus.op_2      = w_out_valid ? w_head.op[2] : '0;

endmodule

// File: tb/tb_vpu_src_port_rd.sv
// Directed bench for vpu_src_port_rd with an address-echo SRAM model.
module tb_vpu_src_port_rd;
    import vpu_src_port_rd_pkg::*;

    localparam int AW  = 10;
    localparam int LW  = 8;
    localparam int LAT = 2;
    localparam int OW  = 32;
    localparam int P   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpu_src_port_rd_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_if ();

    vpu_src_port_rd #(
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SRAM_RD_LAT(LAT), .FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM returns the read address as data; unread ports return junk.
    logic [P-1:0]  sr_en   [LAT];
    logic [AW-1:0] sr_addr [LAT][P];
    always @(posedge clk) begin
        for (int s = LAT - 1; s > 0; s--) begin
            sr_en[s] <= sr_en[s-1];
            for (int p = 0; p < P; p++) sr_addr[s][p] <= sr_addr[s-1][p];
        end
        sr_en[0] <= bus_if.sram_rd_en;
        for (int p = 0; p < P; p++) sr_addr[0][p] <= bus_if.sram_rd_addr[p*AW +: AW];
    end
    always_comb begin
        for (int p = 0; p < P; p++) begin
            bus_if.sram_rd_data[p*OW +: OW] = sr_en[LAT-1][p] ? OW'(sr_addr[LAT-1][p])
                                                              : (32'hBAD0_0000 | OW'(p));
        end
    end

    logic          mon_en = 1'b0;
    int            t0, xfer_n, done_n, done_cyc, out_vld_n, hold_err, outstanding, max_out;
    int            rden_n [P];
    logic [OW-1:0] q_op0[$], q_op1[$], q_op2[$];
    logic [P-1:0]  q_opv[$];
    logic          q_last[$];
    int            q_cyc[$];
    logic [AW-1:0] q_a0[$], q_a2[$];
    logic          prev_stall, prev_last;
    logic [OW-1:0] prev_op0, prev_op1, prev_op2;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.out_valid) out_vld_n++;
            if (prev_stall && !(bus_if.out_valid && bus_if.op_0 == prev_op0 &&
                bus_if.op_1 == prev_op1 && bus_if.op_2 == prev_op2 && bus_if.out_last == prev_last))
                hold_err++;
            prev_stall = bus_if.out_valid && !bus_if.out_ready;
            prev_op0 = bus_if.op_0; prev_op1 = bus_if.op_1; prev_op2 = bus_if.op_2;
            prev_last = bus_if.out_last;
            for (int p = 0; p < P; p++) if (bus_if.sram_rd_en[p]) rden_n[p]++;
            if (bus_if.sram_rd_en[0]) begin
                q_a0.push_back(bus_if.sram_rd_addr[0 +: AW]);
                outstanding++;
            end
            if (bus_if.sram_rd_en[2]) q_a2.push_back(bus_if.sram_rd_addr[2*AW +: AW]);
            if (bus_if.out_valid && bus_if.out_ready) begin
                q_op0.push_back(bus_if.op_0); q_op1.push_back(bus_if.op_1);
                q_op2.push_back(bus_if.op_2); q_opv.push_back(bus_if.op_valid);
                q_last.push_back(bus_if.out_last); q_cyc.push_back(cyc - t0);
                xfer_n++;
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (bus_if.done) begin
                done_n++;
                done_cyc = cyc - t0;
            end
        end
    end

    task automatic clear_mon();
        xfer_n = 0; done_n = 0; done_cyc = -1; out_vld_n = 0; hold_err = 0;
        outstanding = 0; max_out = 0; prev_stall = 1'b0;
        for (int p = 0; p < P; p++) rden_n[p] = 0;
        q_op0.delete(); q_op1.delete(); q_op2.delete(); q_opv.delete();
        q_last.delete(); q_cyc.delete(); q_a0.delete(); q_a2.delete();
        mon_en = 1'b1;
    endtask

    task automatic send_cmd(input logic [AW-1:0] a0, a1, a2, input logic [P-1:0] m,
                            input logic [LW-1:0] len);
        @(posedge clk); #1;
        bus_if.cmd_addr    = {a2, a1, a0};
        bus_if.cmd_op_mask = m;
        bus_if.cmd_len     = len;
        bus_if.cmd_valid   = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done_n >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus_if.cmd_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_cmd_ready got %b exp 1", bus_if.cmd_ready); end
        n_tests++; if ({bus_if.out_valid, bus_if.out_last, bus_if.done} !== 3'b000) begin n_fail++;
            $display("FAIL reset_ctl got %b exp 000", {bus_if.out_valid, bus_if.out_last, bus_if.done}); end
        n_tests++; if ({bus_if.sram_rd_en, bus_if.op_valid} !== 6'b0) begin n_fail++;
            $display("FAIL reset_en_opv got %b exp 0", {bus_if.sram_rd_en, bus_if.op_valid}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_mask();
        bit ok;
        clear_mon();
        bus_if.out_ready = 1'b1;
        send_cmd(10'h010, 10'h020, 10'h030, 3'b111, 8'd4);
        wait_done(1, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL full_timeout got no done exp done"); end
        n_tests++; if (xfer_n !== 4) begin n_fail++; $display("FAIL full_count got %0d exp 4", xfer_n); end
        for (int k = 0; k < xfer_n && k < 4; k++) begin
            n_tests++;
            if ({q_op0[k], q_op1[k], q_op2[k], q_opv[k], q_last[k]} !==
                {32'h10 + OW'(k), 32'h20 + OW'(k), 32'h30 + OW'(k), 3'b111, k == 3}) begin
                n_fail++;
                $display("FAIL full_elem%0d got %h %h %h %b %b", k, q_op0[k], q_op1[k], q_op2[k], q_opv[k], q_last[k]);
            end
            n_tests++; if (q_cyc[k] !== 4 + k) begin n_fail++;
                $display("FAIL full_cycle%0d got %0d exp %0d", k, q_cyc[k], 4 + k); end
        end
        n_tests++; if (done_cyc !== 8) begin n_fail++; $display("FAIL full_done_cyc got %0d exp 8", done_cyc); end
        n_tests++; if (rden_n[2] !== 4) begin n_fail++; $display("FAIL full_rden2 got %0d exp 4", rden_n[2]); end
        repeat (2) @(posedge clk); #1;
        n_tests++; if (done_n !== 1) begin n_fail++; $display("FAIL full_done_pulses got %0d exp 1", done_n); end
    endtask

    task automatic test_two_op();
        bit ok;
        clear_mon();
        send_cmd(10'h040, 10'h050, 10'h060, 3'b011, 8'd3);
        wait_done(1, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL two_timeout got no done exp done"); end
        n_tests++; if (xfer_n !== 3) begin n_fail++; $display("FAIL two_count got %0d exp 3", xfer_n); end
        n_tests++; if (rden_n[2] !== 0) begin n_fail++; $display("FAIL two_rden2 got %0d exp 0", rden_n[2]); end
        for (int k = 0; k < xfer_n && k < 3; k++) begin
            n_tests++;
            if ({q_op0[k], q_op1[k], q_op2[k], q_opv[k], q_last[k]} !==
                {32'h40 + OW'(k), 32'h50 + OW'(k), 32'h0, 3'b011, k == 2}) begin
                n_fail++;
                $display("FAIL two_elem%0d got %h %h %h %b %b", k, q_op0[k], q_op1[k], q_op2[k], q_opv[k], q_last[k]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int rel;
        clear_mon();
        send_cmd(10'h100, 10'h200, 10'h300, 3'b111, 8'd8);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rel = cyc - t0;
            bus_if.out_ready = !(rel >= 5 && rel <= 10);
            if (done_n > 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus_if.out_ready = 1'b1;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got no done exp done"); end
        n_tests++; if (xfer_n !== 8) begin n_fail++; $display("FAIL stall_count got %0d exp 8", xfer_n); end
        for (int k = 0; k < xfer_n && k < 8; k++) begin
            n_tests++;
            if ({q_op0[k], q_op1[k], q_op2[k], q_last[k]} !==
                {32'h100 + OW'(k), 32'h200 + OW'(k), 32'h300 + OW'(k), k == 7}) begin
                n_fail++;
                $display("FAIL stall_elem%0d got %h %h %h %b", k, q_op0[k], q_op1[k], q_op2[k], q_last[k]);
            end
        end
        n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL stall_hold got %0d exp 0", hold_err); end
        n_tests++; if (max_out !== 4) begin n_fail++; $display("FAIL stall_credit got %0d exp 4", max_out); end
    endtask

    task automatic test_len_zero();
        bit ok;
        clear_mon();
        send_cmd(10'h011, 10'h022, 10'h033, 3'b111, 8'd0);
        wait_done(1, 20, ok);
        repeat (4) @(posedge clk); #1;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL len0_timeout got no done exp done"); end
        n_tests++; if (done_cyc !== 1) begin n_fail++; $display("FAIL len0_done_cyc got %0d exp 1", done_cyc); end
        n_tests++; if (rden_n[0] + rden_n[1] + rden_n[2] !== 0) begin n_fail++;
            $display("FAIL len0_rden got %0d exp 0", rden_n[0] + rden_n[1] + rden_n[2]); end
        n_tests++; if (out_vld_n !== 0) begin n_fail++; $display("FAIL len0_out_valid got %0d exp 0", out_vld_n); end
        n_tests++; if (done_n !== 1) begin n_fail++; $display("FAIL len0_done_pulses got %0d exp 1", done_n); end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        logic [AW-1:0] exp_a0 [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [AW-1:0] exp_a2 [4] = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
        clear_mon();
        send_cmd(10'h3FE, 10'h001, 10'h3FD, 3'b111, 8'd4);
        wait_done(1, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout got no done exp done"); end
        n_tests++; if (q_a0.size() !== 4) begin n_fail++; $display("FAIL wrap_issues got %0d exp 4", q_a0.size()); end
        for (int k = 0; k < q_a0.size() && k < 4 && k < q_a2.size(); k++) begin
            n_tests++;
            if ({q_a0[k], q_a2[k]} !== {exp_a0[k], exp_a2[k]}) begin n_fail++;
                $display("FAIL wrap_addr%0d got %h %h exp %h %h", k, q_a0[k], q_a2[k], exp_a0[k], exp_a2[k]); end
        end
        for (int k = 0; k < xfer_n && k < 4; k++) begin
            n_tests++; if (q_op0[k] !== OW'(exp_a0[k])) begin n_fail++;
                $display("FAIL wrap_op0_%0d got %h exp %h", k, q_op0[k], exp_a0[k]); end
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        clear_mon();
        send_cmd(10'h080, 10'h090, 10'h0A0, 3'b111, 8'd8);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus_if.cmd_ready !== 1'b1) begin n_fail++;
            $display("FAIL abort_cmd_ready got %b exp 1", bus_if.cmd_ready); end
        n_tests++;
        if ({bus_if.sram_rd_en, bus_if.sram_rd_addr, bus_if.out_valid, bus_if.op_valid,
             bus_if.out_last, bus_if.done, bus_if.op_0, bus_if.op_1, bus_if.op_2} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs got en=%b addr=%h vld=%b opv=%b exp all 0",
                     bus_if.sram_rd_en, bus_if.sram_rd_addr, bus_if.out_valid, bus_if.op_valid);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        n_tests++; if (out_vld_n !== 0) begin n_fail++; $display("FAIL abort_stale got %0d exp 0", out_vld_n); end
        clear_mon();
        send_cmd(10'h1C0, 10'h1D0, 10'h1E0, 3'b111, 8'd2);
        wait_done(1, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_new_timeout got no done exp done"); end
        n_tests++; if (xfer_n !== 2) begin n_fail++; $display("FAIL abort_new_count got %0d exp 2", xfer_n); end
        for (int k = 0; k < xfer_n && k < 2; k++) begin
            n_tests++;
            if ({q_op0[k], q_op2[k], q_last[k]} !== {32'h1C0 + OW'(k), 32'h1E0 + OW'(k), k == 1}) begin
                n_fail++;
                $display("FAIL abort_new_elem%0d got %h %h %b", k, q_op0[k], q_op2[k], q_last[k]);
            end
        end
        n_tests++; if (done_cyc !== 6) begin n_fail++; $display("FAIL abort_new_done_cyc got %0d exp 6", done_cyc); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        @(posedge clk); #1;
        bus_if.cmd_addr = {10'h0C0, 10'h0B0, 10'h0A5}; bus_if.cmd_op_mask = 3'b111;
        bus_if.cmd_len = 8'd1; bus_if.cmd_valid = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        bus_if.cmd_addr = {10'h2C0, 10'h2B0, 10'h2A5};
        repeat (6) @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        wait_done(2, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout got %0d dones exp 2", done_n); end
        n_tests++; if (xfer_n !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", xfer_n); end
        if (xfer_n >= 2) begin
            n_tests++; if ({q_op0[0], q_cyc[0]} !== {32'h0A5, 32'd4}) begin n_fail++;
                $display("FAIL b2b_first got %h@%0d exp 0a5@4", q_op0[0], q_cyc[0]); end
            n_tests++; if ({q_op0[1], q_cyc[1]} !== {32'h2A5, 32'd10}) begin n_fail++;
                $display("FAIL b2b_second got %h@%0d exp 2a5@10", q_op0[1], q_cyc[1]); end
        end
        n_tests++; if (done_cyc !== 11) begin n_fail++; $display("FAIL b2b_done_cyc got %0d exp 11", done_cyc); end
    endtask

    initial begin
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_addr    = '0;
        bus_if.cmd_op_mask = 3'b111;
        bus_if.cmd_len     = '0;
        bus_if.out_ready   = 1'b1;
        t0 = 0;
        test_reset();
        test_full_mask();
        test_two_op();
        test_stall();
        test_len_zero();
        test_addr_wrap();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vpu_src_port_rd.md
Name: vpu_src_port_rd

Overview:
Operand source engine that feeds the VPU ALU lanes (MAX/MIN/ADD, etc.). It accepts a vector command from VPU_CONTROLLER and issues per-element reads on up to SRAM_R_PORT_CNT SRAM read ports. It absorbs the fixed SRAM read latency and presents aligned op_0/op_1/op_2 with an op_valid mask under a valid/ready handshake. It is the transmitter side of the op_*/op_valid interface that the ALU units consume.

Parameters:
OPERAND_WIDTH, VPU_PKG::OPERAND_WIDTH (32), operand bit width
SRAM_R_PORT_CNT, VPU_PKG::SRAM_R_PORT_CNT (3), number of read ports / operands
ADDR_WIDTH, 10, SRAM word address width
LEN_WIDTH, 8, vector length field width
SRAM_RD_LAT, 2, cycles from sram_rd_en to sram_rd_data valid (>=1)
FIFO_DEPTH, 4, output buffer entries (must be >= SRAM_RD_LAT+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_addr  in  SRAM_R_PORT_CNT*ADDR_WIDTH  start address per port; port i in slice i
cmd_op_mask  in  SRAM_R_PORT_CNT  ports used (legal values: 3'b011 or 3'b111)
cmd_len  in  LEN_WIDTH  element count
sram_rd_en  out  SRAM_R_PORT_CNT  per-port read strobe
sram_rd_addr  out  SRAM_R_PORT_CNT*ADDR_WIDTH  per-port read address
sram_rd_data  in  SRAM_R_PORT_CNT*OPERAND_WIDTH  read data, valid SRAM_RD_LAT cycles after rd_en
op_0, op_1, op_2  out  OPERAND_WIDTH each  operands to ALU
op_valid  out  SRAM_R_PORT_CNT  operand-valid mask; bit SRAM_R_PORT_CNT-1 marks op_2 valid
out_valid  out  1  operand set valid
out_ready  in  1  ALU pipeline accepts
out_last  out  1  final element of the command
done  out  1  one-cycle pulse: command complete

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM=IDLE; FIFO and in-flight pipe cleared; all outputs 0 except cmd_ready=1. Reset mid-command aborts it. SRAM data returning after reset is discarded.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch addresses, mask and len. Go to ISSUE if len!=0; if len==0 go to DONE.
  - ISSUE: issue one element per cycle when fifo_count+inflight_count < FIFO_DEPTH. On issue, assert sram_rd_en[i] only for mask bits set; drive sram_rd_addr of unused ports as 0; all active addresses +1. Address wraps modulo 2^ADDR_WIDTH. After the last issue, go to DRAIN.
  - DRAIN: wait until the last element is accepted downstream, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in ISSUE, DRAIN and DONE.
- In-flight tracking: SRAM_RD_LAT-deep valid/last shift register. The entry is pushed into the FIFO in the cycle the data arrives. Unmasked operand lanes are stored as 0.
- Output: FIFO head is registered. out_valid=!empty. Transfer on out_valid&out_ready. The op_* and out_last outputs hold stable while out_valid&!out_ready. op_valid = latched mask while out_valid, otherwise 0.
- Latency with no stall: accept at cycle 0, rd_en at 1, data at 1+SRAM_RD_LAT, out_valid at 2+SRAM_RD_LAT (cycle 4 at default).
- Throughput: one element per cycle with out_ready held at 1.
- The credit rule guarantees no overflow; SRAM returns cannot be stalled. Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- done asserts the cycle after the out_last transfer. Back-to-back commands carry a 2-cycle bubble (DONE then IDLE accept).
- An illegal mask (bit0 or bit1 clear) is not checked; the bench must not drive it.

Decomposition:
- Additions to VPU_PKG: SRAM_RD_LAT, SRC_FIFO_DEPTH, src_state_t enum {IDLE, ISSUE, DRAIN, DONE}, and a packed src_entry_t {op[SRAM_R_PORT_CNT], last}.
- One sub-module, vpu_src_fifo: synchronous FIFO of src_entry_t with count output, using the same clk/rst_n.

Test Plan:
1. mask=111, len=4, addr={0x10,0x20,0x30}, SRAM returns addr as data, out_ready=1 -> 4 consecutive out_valid starting cycle 4; op_0=0x10..0x13, op_1=0x20..0x23, op_2=0x30..0x33; op_valid=111; out_last on the 4th; done at the next cycle.
2. mask=011, len=3 -> sram_rd_en[2] never asserted; op_2=0; op_valid=011 on all 3 outputs.
3. len=8, out_ready low for cycles 5-10 -> outputs held stable; fifo_count+inflight never exceeds 4; all 8 elements delivered in order with no loss or duplication.
4. len=0 -> no sram_rd_en; done pulses 1 cycle after accept; no out_valid.
5. addr0=0x3FE, len=4 -> port-0 addresses 0x3FE, 0x3FF, 0x000, 0x001.
6. rst_n=0 mid-ISSUE of len=8 -> next cycle all outputs 0 and cmd_ready=1; a new command afterward runs cleanly, with no stale data from the aborted one.
